// File: rtl/matrix_core_sequencer_if.sv
// matrix_core_sequencer_if
//   Bundles the host-side buffer/control port and the MAC-core port of the
//   matrix core sequencer.
//   slave  : the sequencer (receives writes/start and mac_acc, drives status and MAC operands)
//   master : the environment (host + MAC core)
//   Host side : wr_en, wr_sel, wr_addr, wr_data, len, start -> ; <- busy, done, result
//   MAC side  : <- mac_a, mac_b, mac_m_rst ; mac_acc ->
interface matrix_core_sequencer_if #(
   parameter int unsigned W  = 32,
   parameter int unsigned AW = 3
);
   logic          wr_en;
   logic          wr_sel;
   logic [AW-1:0] wr_addr;
   logic [W-1:0]  wr_data;
   logic [AW:0]   len;
   logic          start;
   logic          busy;
   logic          done;
   logic [W-1:0]  result;
   logic [W-1:0]  mac_a;
   logic [W-1:0]  mac_b;
   logic          mac_m_rst;
   logic [W-1:0]  mac_acc;

   modport slave (
      input  wr_en, wr_sel, wr_addr, wr_data, len, start, mac_acc,
      output busy, done, result, mac_a, mac_b, mac_m_rst
   );

   modport master (
      output wr_en, wr_sel, wr_addr, wr_data, len, start, mac_acc,
      input  busy, done, result, mac_a, mac_b, mac_m_rst
   );
endinterface

// File: rtl/matrix_core_sequencer.sv
// matrix_core_sequencer
//   Holds one A-row and one B-column, streams operand pairs into a free-running
//   MAC core on start, waits for its pipeline to drain and captures the dot product.
//   clk  : single rising-edge clock
//   rst  : synchronous active-high reset (clears FSM, buffers, outputs)
//   bus  : matrix_core_sequencer_if.slave
//          host : wr_en/wr_sel/wr_addr/wr_data buffer writes (IDLE only),
//                 len/start sequence request, busy/done/result status
//          MAC  : mac_a/mac_b operands and mac_m_rst restart (all registered),
//                 mac_acc accumulator input
module matrix_core_sequencer #(
   parameter int unsigned W     = 32,
   parameter int unsigned N_MAX = 8,
   parameter int unsigned AW    = 3
) (
   input logic                    clk,
   input logic                    rst,
   matrix_core_sequencer_if.slave bus
);

   localparam logic [AW:0]   LenMax = (AW + 1)'(N_MAX);
   localparam logic [AW:0]   LenOne = (AW + 1)'(1);
   localparam logic [AW-1:0] IdxOne = AW'(1);

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StDrain,
      StCapture
   } state_e;

   state_e        state_q, state_d;
   logic [AW-1:0] idx_q, idx_d;
   logic [AW:0]   len_q, len_d;
   logic          drain_cnt_q, drain_cnt_d;
   logic [W-1:0]  a_buf_q [N_MAX];
   logic [W-1:0]  a_buf_d [N_MAX];
   logic [W-1:0]  b_buf_q [N_MAX];
   logic [W-1:0]  b_buf_d [N_MAX];
   logic [W-1:0]  mac_a_q, mac_a_d;
   logic [W-1:0]  mac_b_q, mac_b_d;
   logic          mac_m_rst_q, mac_m_rst_d;
   logic [W-1:0]  result_q, result_d;

   logic start_ok;
   logic last_elem;

   assign start_ok  = bus.start && (bus.len >= LenOne) && (bus.len <= LenMax);
   assign last_elem = ({1'b0, idx_q} == (len_q - LenOne));

   // Next-state and control
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      len_d       = len_q;
      drain_cnt_d = drain_cnt_q;

      unique case (state_q)
         StIdle: begin
            if (start_ok) begin
               state_d = StIssue;
               idx_d   = '0;
               len_d   = bus.len;
            end
         end
         StIssue: begin
            if (last_elem) begin
               state_d     = StDrain;
               drain_cnt_d = 1'b0;
            end else begin
               idx_d = idx_q + IdxOne;
            end
         end
         StDrain: begin
            if (drain_cnt_q) begin
               state_d     = StCapture;
               drain_cnt_d = 1'b0;
            end else begin
               drain_cnt_d = 1'b1;
            end
         end
         StCapture: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Buffer writes are only honoured while idle. A write coinciding with an
   // accepted start lands in the buffer, but element 0 is launched from the
   // pre-write contents because the operand registers read the _q copy.
   always_comb begin
      a_buf_d = a_buf_q;
      b_buf_d = b_buf_q;
      if ((state_q == StIdle) && bus.wr_en) begin
         if (bus.wr_sel) begin
            b_buf_d[bus.wr_addr] = bus.wr_data;
         end else begin
            a_buf_d[bus.wr_addr] = bus.wr_data;
         end
      end
   end

   // Operands are registered one stage ahead of the state so element k appears
   // on mac_a/mac_b in the k-th ISSUE cycle; zero everywhere else keeps mac_acc frozen.
   always_comb begin
      mac_a_d = '0;
      mac_b_d = '0;
      if (state_d == StIssue) begin
         mac_a_d = a_buf_q[idx_d];
         mac_b_d = b_buf_q[idx_d];
      end
   end

   // Restart lands in the cycle the MAC presents its registered product of element 0.
   always_comb begin
      mac_m_rst_d = (state_q == StIssue) && (idx_q == '0);
   end

   // Sample mac_acc in the last drain cycle so result is valid alongside done.
   always_comb begin
      result_d = result_q;
      if ((state_q == StDrain) && drain_cnt_q) begin
         result_d = bus.mac_acc;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         idx_q       <= '0;
         len_q       <= '0;
         drain_cnt_q <= 1'b0;
         a_buf_q     <= '{default: '0};
         b_buf_q     <= '{default: '0};
         mac_a_q     <= '0;
         mac_b_q     <= '0;
         mac_m_rst_q <= 1'b0;
         result_q    <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         len_q       <= len_d;
         drain_cnt_q <= drain_cnt_d;
         a_buf_q     <= a_buf_d;
         b_buf_q     <= b_buf_d;
         mac_a_q     <= mac_a_d;
         mac_b_q     <= mac_b_d;
         mac_m_rst_q <= mac_m_rst_d;
         result_q    <= result_d;
      end
   end

   assign bus.busy      = (state_q != StIdle);
   assign bus.done      = (state_q == StCapture);
   assign bus.result    = result_q;
   assign bus.mac_a     = mac_a_q;
   assign bus.mac_b     = mac_b_q;
   assign bus.mac_m_rst = mac_m_rst_q;

endmodule

// File: tb/tb_matrix_core_sequencer.sv
// Bench for matrix_core_sequencer: models the external MAC core (registered
// product, accumulator restarted by mac_m_rst) and predicts each dot product
// from a shadow copy of the operand buffers.
module tb_matrix_core_sequencer;

   localparam int W  = 32;
   localparam int AW = 3;
   localparam int NM = 8;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   logic [W-1:0] a_mdl [NM];
   logic [W-1:0] b_mdl [NM];
   logic [W-1:0] last_res;
   logic [W-1:0] mac_p;

   matrix_core_sequencer_if #(.W(W), .AW(AW)) bus ();

   matrix_core_sequencer #(.W(W), .N_MAX(NM), .AW(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // External MAC core: product register, then accumulator (restart loads the product).
   always @(posedge clk) begin
      mac_p <= bus.mac_a * bus.mac_b;
      if (bus.mac_m_rst) bus.mac_acc <= mac_p;
      else               bus.mac_acc <= bus.mac_acc + mac_p;
   end

   task automatic write_elem(input bit sel, input int addr, input logic [W-1:0] data);
      bus.wr_en   = 1'b1;
      bus.wr_sel  = sel;
      bus.wr_addr = AW'(addr);
      bus.wr_data = data;
      @(negedge clk);
      bus.wr_en = 1'b0;
      if (sel) b_mdl[addr] = data;
      else     a_mdl[addr] = data;
   endtask

   // Issues start with length n in the current cycle S and checks every cycle
   // S+1..S+n+4. With disturb set, a write to A0 and a second start are
   // presented in cycle S+2 and must both be ignored.
   task automatic run_seq(input int n, input bit disturb);
      logic [W-1:0] exp_res;
      logic [W-1:0] exp_a;
      logic [W-1:0] exp_b;
      logic         exp_busy;
      logic         exp_done;
      logic         exp_mrst;
      exp_res = '0;
      for (int i = 0; i < n; i++) exp_res = exp_res + a_mdl[i] * b_mdl[i];
      bus.len   = (AW + 1)'(n);
      bus.start = 1'b1;
      for (int cyc = 1; cyc <= n + 4; cyc++) begin
         @(negedge clk);
         bus.start = 1'b0;
         bus.wr_en = 1'b0;
         exp_busy  = (cyc <= n + 3);
         exp_done  = (cyc == n + 3);
         exp_mrst  = (cyc == 2);
         exp_a     = (cyc <= n) ? a_mdl[cyc-1] : '0;
         exp_b     = (cyc <= n) ? b_mdl[cyc-1] : '0;
         checks++;
         if (bus.busy !== exp_busy) begin
            errors++;
            $display("FAIL busy len=%0d cyc=S+%0d got %b want %b", n, cyc, bus.busy, exp_busy);
         end
         checks++;
         if (bus.done !== exp_done) begin
            errors++;
            $display("FAIL done len=%0d cyc=S+%0d got %b want %b", n, cyc, bus.done, exp_done);
         end
         checks++;
         if (bus.mac_m_rst !== exp_mrst) begin
            errors++;
            $display("FAIL mac_m_rst len=%0d cyc=S+%0d got %b want %b", n, cyc, bus.mac_m_rst,
                     exp_mrst);
         end
         checks++;
         if (bus.mac_a !== exp_a || bus.mac_b !== exp_b) begin
            errors++;
            $display("FAIL operands len=%0d cyc=S+%0d got a=%h b=%h want a=%h b=%h", n, cyc,
                     bus.mac_a, bus.mac_b, exp_a, exp_b);
         end
         if (cyc >= n + 3) begin
            checks++;
            if (bus.result !== exp_res) begin
               errors++;
               $display("FAIL result len=%0d cyc=S+%0d got %h want %h", n, cyc, bus.result,
                        exp_res);
            end
         end
         if (disturb && cyc == 2) begin
            bus.wr_en   = 1'b1;
            bus.wr_sel  = 1'b0;
            bus.wr_addr = '0;
            bus.wr_data = 32'h0000DEAD;
            bus.len     = 4'd4;
            bus.start   = 1'b1;
         end
      end
      last_res = exp_res;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.mac_m_rst !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl got busy=%b done=%b mrst=%b want 0 0 0", bus.busy, bus.done,
                  bus.mac_m_rst);
      end
      checks++;
      if (bus.mac_a !== '0 || bus.mac_b !== '0 || bus.result !== '0) begin
         errors++;
         $display("FAIL reset_data got a=%h b=%h result=%h want 0", bus.mac_a, bus.mac_b,
                  bus.result);
      end
      for (int i = 0; i < NM; i++) begin
         a_mdl[i] = '0;
         b_mdl[i] = '0;
      end
   endtask

   task automatic test_basic();
      for (int i = 0; i < 4; i++) begin
         write_elem(1'b0, i, 32'(i + 1));
         write_elem(1'b1, i, 32'(i + 5));
      end
      run_seq(4, 1'b0);
      checks++;
      if (last_res !== 32'd70) begin
         errors++;
         $display("FAIL basic_model got %0d want 70", last_res);
      end
   endtask

   task automatic test_back_to_back();
      write_elem(1'b0, 0, 32'd7);
      write_elem(1'b1, 0, 32'd9);
      run_seq(1, 1'b0);
      run_seq(1, 1'b0);
      checks++;
      if (bus.result !== 32'd63) begin
         errors++;
         $display("FAIL restart got %0d want 63", bus.result);
      end
   endtask

   task automatic test_wrap();
      write_elem(1'b0, 0, 32'hFFFF_FFFF);
      write_elem(1'b1, 0, 32'd2);
      write_elem(1'b0, 1, 32'd1);
      write_elem(1'b1, 1, 32'd3);
      run_seq(2, 1'b0);
      checks++;
      if (bus.result !== 32'h0000_0001) begin
         errors++;
         $display("FAIL wrap got %h want 00000001", bus.result);
      end
   endtask

   task automatic test_illegal();
      int bad_len [2];
      bad_len[0] = 0;
      bad_len[1] = 9;
      for (int j = 0; j < 2; j++) begin
         bus.len   = (AW + 1)'(bad_len[j]);
         bus.start = 1'b1;
         @(negedge clk);
         bus.start = 1'b0;
         for (int c = 0; c < 6; c++) begin
            checks++;
            if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
               errors++;
               $display("FAIL illegal_len%0d got busy=%b done=%b want 0 0", bad_len[j], bus.busy,
                        bus.done);
            end
            @(negedge clk);
         end
      end
      // Busy-time write and start must be dropped; the follow-up run re-reads A0.
      for (int i = 0; i < 4; i++) begin
         write_elem(1'b0, i, 32'(i + 11));
         write_elem(1'b1, i, 32'(i + 21));
      end
      run_seq(4, 1'b1);
      run_seq(4, 1'b0);
   endtask

   task automatic test_reset_mid();
      bus.len   = 4'd4;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (bus.busy !== 1'b0 || bus.mac_a !== '0 || bus.mac_b !== '0 || bus.mac_m_rst !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid got busy=%b a=%h b=%h mrst=%b want 0", bus.busy, bus.mac_a,
                  bus.mac_b, bus.mac_m_rst);
      end
      for (int i = 0; i < NM; i++) begin
         a_mdl[i] = '0;
         b_mdl[i] = '0;
      end
      for (int c = 0; c < 8; c++) begin
         checks++;
         if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort got done=%b busy=%b want 0 0", bus.done, bus.busy);
         end
         @(negedge clk);
      end
      // Element 1 was nonzero before reset; the cleared buffer must contribute 0.
      write_elem(1'b0, 0, 32'd2);
      write_elem(1'b1, 0, 32'd3);
      run_seq(2, 1'b0);
      checks++;
      if (bus.result !== 32'd6) begin
         errors++;
         $display("FAIL reset_reload got %0d want 6", bus.result);
      end
   endtask

   task automatic test_hold();
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         checks++;
         if (bus.result !== last_res || bus.mac_a !== '0 || bus.mac_b !== '0 ||
             bus.done !== 1'b0) begin
            errors++;
            $display("FAIL hold cyc=%0d got result=%h a=%h b=%h done=%b want %h 0 0 0", c,
                     bus.result, bus.mac_a, bus.mac_b, bus.done, last_res);
         end
      end
   endtask

   task automatic test_random();
      int n;
      for (int it = 0; it < 8; it++) begin
         n = $urandom_range(1, NM);
         for (int i = 0; i < NM; i++) begin
            if ($urandom_range(0, 3) != 0) write_elem(1'b0, i, 32'($urandom));
            if ($urandom_range(0, 3) != 0) write_elem(1'b1, i, 32'($urandom));
         end
         run_seq(n, 1'b0);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      rst         = 1'b1;
      bus.wr_en   = 1'b0;
      bus.wr_sel  = 1'b0;
      bus.wr_addr = '0;
      bus.wr_data = '0;
      bus.len     = '0;
      bus.start   = 1'b0;
      @(negedge clk);
      test_reset();
      test_basic();
      test_back_to_back();
      test_wrap();
      test_illegal();
      test_reset_mid();
      test_hold();
      test_random();
      test_hold();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
